uart_watch_cmd_ctrl: RTL
========================

Name: uart_watch_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the watch/stopwatch datapath.
- Decodes ASCII bytes from the UART RX into mode, field-select and one-cycle control pulses (up/down/run-stop/clear).
- Arbitrates those pulses against the debounced front-panel buttons.
- Queues an echo/acknowledge character per command and feeds it to the UART TX through a busy handshake.

Parameters:
- ECHO_DEPTH, 4, echo FIFO depth in entries; power of two, ≥2.
- CASE_FOLD, 1, 1 = lower-case letters are accepted as the upper-case command; 0 = lower-case letters are invalid.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte; valid when rx_done=1
- rx_done  in  1  one-cycle strobe from UART RX
- btn_up  in  1  debounced one-cycle pulse
- btn_down  in  1  debounced one-cycle pulse
- btn_runstop  in  1  debounced one-cycle pulse
- btn_clear  in  1  debounced one-cycle pulse
- tx_busy  in  1  UART TX busy
- mode  out  1  0 = watch, 1 = stopwatch
- sel  out  2  watch field select: 0 none, 1 hour, 2 min, 3 sec
- o_up  out  1  one-cycle pulse to datapath
- o_down  out  1  one-cycle pulse to datapath
- o_runstop  out  1  one-cycle pulse to datapath
- o_clear  out  1  one-cycle pulse to datapath
- cmd_err  out  1  one-cycle pulse on an invalid command
- echo_ovf  out  1  sticky; set when an echo is dropped
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle TX start strobe

Behaviour:
- Reset values: mode=0, sel=0, every pulse output 0, cmd_err=0, echo_ovf=0, tx_data=0x00, tx_start=0. The FIFO is emptied, the pending slot is cleared and the TX FSM returns to IDLE.
- Reset mid-transfer: abandon the transfer and do not wait on tx_busy.
- Decode of a byte captured on rx_done=1, with case folding applied first:
  - 'M' (0x4D): toggle mode; force sel=0.
  - '0'..'3': sel = digit value. Watch mode only.
  - 'U' / 'D': o_up / o_down pulse. Watch mode and sel≠0 only.
  - 'G': o_runstop pulse. Stopwatch mode only.
  - 'C': o_clear pulse. Stopwatch mode only.
  - Any other byte, or a command outside its allowed mode/sel: no state change; cmd_err pulses.
- Latency: rx_done in cycle n → mode/sel update and the output pulse (or cmd_err) in cycle n+1.
- Buttons:
  - Pass straight through to the matching output with 1 cycle of latency.
  - Not mode-gated (the datapath gates them).
  - Multiple simultaneous buttons map to multiple simultaneous outputs.
- Arbitration:
  - If any btn_* pulses in the same cycle as rx_done, the button pulses take n+1. The decoded UART action is held in a 1-entry pending slot and issued in n+2.
  - mode/sel updates are never deferred; they apply in n+1.
  - If rx_done arrives while the pending slot is still occupied: drop the new byte, pulse cmd_err, do not echo it.
- Echo:
  - Every processed byte pushes one FIFO entry in cycle n+1: the byte itself (after folding) if valid, else '?' (0x3F).
  - FIFO full on push: discard the entry; echo_ovf=1 until rst.
  - Pointers wrap modulo ECHO_DEPTH. A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- TX FSM:
  - IDLE: if the FIFO is non-empty and tx_busy=0, pop the head, drive tx_data, pulse tx_start for 1 cycle, then go to WAIT_HI.
  - WAIT_HI: go to WAIT_LO when tx_busy=1. If tx_busy is still 0 after 16 cycles, go to WAIT_LO anyway.
  - WAIT_LO: go to IDLE when tx_busy=0.
  - tx_data holds its value from tx_start until the next pop.
- At most one tx_start per FSM round trip; never assert tx_start while tx_busy=1.

Test Plan:
- After reset, send 'M' (0x4D) → mode=1 and sel=0 one cycle after rx_done; tx_start with tx_data=0x4D; no cmd_err.
- From mode=0, send '3' then 'U' → sel=3, then one o_up pulse exactly one cycle after the second rx_done; echoes 0x33 then 0x55 in order.
- From mode=0, sel=0, send 'U' and 'G' → two cmd_err pulses, no o_up/o_runstop, echoes 0x3F 0x3F. Then send 'M','g' with CASE_FOLD=1 → mode=1, o_runstop pulse, echo 0x47.
- rx_done ('C', mode=1) in the same cycle as btn_up → o_up at n+1, o_clear at n+2, never both in one cycle.
- Hold tx_busy=1 and send 6 valid bytes with ECHO_DEPTH=4 → 4 entries queued, echo_ovf=1. Release tx_busy → exactly 4 tx_start strobes with the first four bytes in order.
- Assert rst while in WAIT_LO with a non-empty FIFO → all outputs at reset values next cycle; no tx_start until new rx_done.

Source files
------------

// File: rtl/uart_watch_cmd_ctrl.sv
// UART command sequencer for the watch/stopwatch datapath: decodes RX bytes into
// mode/sel/control pulses, merges them with front-panel buttons and echoes each command to TX.
module uart_watch_cmd_ctrl #(
    parameter int unsigned ECHO_DEPTH = 4,
    parameter bit          CASE_FOLD  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_runstop,
    input  logic       btn_clear,
    input  logic       tx_busy,
    output logic       mode,
    output logic [1:0] sel,
    output logic       o_up,
    output logic       o_down,
    output logic       o_runstop,
    output logic       o_clear,
    output logic       cmd_err,
    output logic       echo_ovf,
    output logic [7:0] tx_data,
    output logic       tx_start
);

    localparam int unsigned AW = $clog2(ECHO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(ECHO_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_HI,
        TX_WAIT_LO
    } tx_state_t;

    // Action vectors are ordered {clear, runstop, down, up}.
    logic            mode_q, mode_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0]      pulse_q, pulse_d;
    logic            cmd_err_q, cmd_err_d;
    logic            echo_ovf_q, echo_ovf_d;
    logic            pend_valid_q, pend_valid_d;
    logic [3:0]      pend_act_q, pend_act_d;
    logic [7:0]      mem_q [ECHO_DEPTH];
    logic [7:0]      mem_d [ECHO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    tx_state_t       state_q, state_d;
    logic [3:0]      hi_cnt_q, hi_cnt_d;

    logic [7:0]      rx_fold;
    logic            cmd_valid;
    logic [3:0]      cmd_act;
    logic            mode_n;
    logic [1:0]      sel_n;
    logic [3:0]      btn_vec;
    logic            any_btn;
    logic            push;
    logic            do_push;
    logic            pop;
    logic [7:0]      push_data;

    assign btn_vec = {btn_clear, btn_runstop, btn_down, btn_up};
    assign any_btn = |btn_vec;

    always_comb begin
        rx_fold = rx_data;
        if (CASE_FOLD && (rx_data >= 8'h61) && (rx_data <= 8'h7A)) begin
            rx_fold = rx_data - 8'h20;
        end
    end

    // Validity depends on the mode/sel in force when the byte arrives.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_act   = '0;
        mode_n    = mode_q;
        sel_n     = sel_q;
        case (rx_fold)
            8'h4D: begin
                cmd_valid = 1'b1;
                mode_n    = ~mode_q;
                sel_n     = 2'd0;
            end
            8'h30, 8'h31, 8'h32, 8'h33: begin
                if (!mode_q) begin
                    cmd_valid = 1'b1;
                    sel_n     = rx_fold[1:0];
                end
            end
            8'h55: begin
                if (!mode_q && (sel_q != 2'd0)) begin
                    cmd_valid = 1'b1;
                    cmd_act   = 4'b0001;
                end
            end
            8'h44: begin
                if (!mode_q && (sel_q != 2'd0)) begin
                    cmd_valid = 1'b1;
                    cmd_act   = 4'b0010;
                end
            end
            8'h47: begin
                if (mode_q) begin
                    cmd_valid = 1'b1;
                    cmd_act   = 4'b0100;
                end
            end
            8'h43: begin
                if (mode_q) begin
                    cmd_valid = 1'b1;
                    cmd_act   = 4'b1000;
                end
            end
            default: ;
        endcase
    end

    // A pending slot is only ever occupied for one cycle, so a byte arriving
    // then is the only one that can collide with it.
    always_comb begin
        mode_d       = mode_q;
        sel_d        = sel_q;
        cmd_err_d    = 1'b0;
        pend_valid_d = 1'b0;
        pend_act_d   = pend_act_q;
        pulse_d      = btn_vec | (pend_valid_q ? pend_act_q : 4'b0000);
        push         = 1'b0;
        push_data    = cmd_valid ? rx_fold : 8'h3F;
        if (rx_done && pend_valid_q) begin
            cmd_err_d = 1'b1;
        end else if (rx_done) begin
            push = 1'b1;
            if (cmd_valid) begin
                mode_d = mode_n;
                sel_d  = sel_n;
                if (any_btn) begin
                    pend_valid_d = |cmd_act;
                    pend_act_d   = cmd_act;
                end else begin
                    pulse_d = pulse_d | cmd_act;
                end
            end else begin
                cmd_err_d = 1'b1;
            end
        end
    end

    assign pop     = (state_q == TX_IDLE) && (cnt_q != '0) && !tx_busy;
    assign do_push = push && ((cnt_q != FULL_CNT) || pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        echo_ovf_d = echo_ovf_q | (push && !do_push);
        tx_data_d  = tx_data_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            tx_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + AW'(1);
        end
        if (do_push && !pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!do_push && pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        hi_cnt_d = hi_cnt_q;
        case (state_q)
            TX_IDLE: begin
                if (pop) begin
                    state_d  = TX_WAIT_HI;
                    hi_cnt_d = '0;
                end
            end
            TX_WAIT_HI: begin
                if (tx_busy || (hi_cnt_q == 4'd15)) begin
                    state_d = TX_WAIT_LO;
                end else begin
                    hi_cnt_d = hi_cnt_q + 4'd1;
                end
            end
            TX_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 1'b0;
            sel_q        <= 2'd0;
            pulse_q      <= '0;
            cmd_err_q    <= 1'b0;
            echo_ovf_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_act_q   <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            state_q      <= TX_IDLE;
            hi_cnt_q     <= '0;
        end else begin
            mode_q       <= mode_d;
            sel_q        <= sel_d;
            pulse_q      <= pulse_d;
            cmd_err_q    <= cmd_err_d;
            echo_ovf_q   <= echo_ovf_d;
            pend_valid_q <= pend_valid_d;
            pend_act_q   <= pend_act_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            state_q      <= state_d;
            hi_cnt_q     <= hi_cnt_d;
        end
    end

    assign mode      = mode_q;
    assign sel       = sel_q;
    assign o_up      = pulse_q[0];
    assign o_down    = pulse_q[1];
    assign o_runstop = pulse_q[2];
    assign o_clear   = pulse_q[3];
    assign cmd_err   = cmd_err_q;
    assign echo_ovf  = echo_ovf_q;
    // Strobe and data are presented in the pop cycle so tx_busy is never high under tx_start.
    assign tx_start  = pop;
    assign tx_data   = tx_data_d;

endmodule
